// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex timer: FSM states, BCD digits,
// LFSR taps and the LFSR step function.
package reflex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  typedef logic [3:0] digit_t;

  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam digit_t      DIGIT_E   = 4'hE;
  localparam digit_t      DIGIT_9   = 4'h9;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_cnt4.sv
// Four-digit BCD up-counter with synchronous clear, increment enable and
// saturation at 9999 (sat flags the all-nines value).
module bcd_cnt4 import reflex_pkg::*; (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       sat
);

  assign sat = (d0 == DIGIT_9) && (d1 == DIGIT_9) && (d2 == DIGIT_9) && (d3 == DIGIT_9);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (clr) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (inc && !sat) begin
      if (d0 != DIGIT_9) begin
        d0 <= d0 + 4'd1;
      end else begin
        d0 <= '0;
        if (d1 != DIGIT_9) begin
          d1 <= d1 + 4'd1;
        end else begin
          d1 <= '0;
          if (d2 != DIGIT_9) begin
            d2 <= d2 + 4'd1;
          end else begin
            // d3 cannot be 9 here, otherwise sat would have blocked inc
            d2 <= '0;
            d3 <= d3 + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/reflex_timer.sv
// Reaction timer: random wait, then lights led and counts ms in BCD until stop.
// Define REFLEX_BEST_EN to keep a best-time register on seg4..seg7.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// WAIT    | random delay running, led off
// RUN     | led on, current time counting
// DONE    | reaction captured (or saturated at 9999)
// FAULT   | stop pressed during WAIT, current shows EEEE
module reflex_timer import reflex_pkg::*; #(
  parameter int          TICK_DIV    = 100_000,
  parameter int          MIN_WAIT_MS = 1000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic       led,
  output logic [3:0] seg0,
  output logic [3:0] seg1,
  output logic [3:0] seg2,
  output logic [3:0] seg3,
  output logic [3:0] seg4,
  output logic [3:0] seg5,
  output logic [3:0] seg6,
  output logic [3:0] seg7
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W = $clog2(MIN_WAIT_MS + 2048);

  state_t              state, state_nxt;
  logic [PRE_W-1:0]    presc;
  logic                tick;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [15:0]         lfsr;
  logic                cnt_clr, cnt_inc, cnt_sat, wait_load;
  logic [3:0]          c0, c1, c2, c3;

  assign tick = (presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wait_load = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_nxt = S_WAIT;
          cnt_clr   = 1'b1;
          wait_load = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop)                                  state_nxt = S_FAULT;
        else if (tick && wait_cnt == WAIT_W'(1))   state_nxt = S_RUN;
      end
      S_RUN: begin
        // stop wins over a coincident tick, so the frozen value is not bumped
        if (stop)                  state_nxt = S_DONE;
        else if (tick && cnt_sat)  state_nxt = S_DONE;
        else if (tick)             cnt_inc   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Restarting on every state change gives a full tick period after entering WAIT or RUN
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)                           presc <= '0;
    else if (state_nxt != state || tick)  presc <= '0;
    else                                  presc <= presc + PRE_W'(1);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (wait_load)
      wait_cnt <= WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr[10:0]);
    else if (state == S_WAIT && tick && wait_cnt != '0)
      wait_cnt <= wait_cnt - WAIT_W'(1);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= (state_nxt == S_RUN);
  end

  bcd_cnt4 u_cur (
    .ck    (ck),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .d0    (c0),
    .d1    (c1),
    .d2    (c2),
    .d3    (c3),
    .sat   (cnt_sat)
  );

  assign seg0 = (state == S_FAULT) ? DIGIT_E : c0;
  assign seg1 = (state == S_FAULT) ? DIGIT_E : c1;
  assign seg2 = (state == S_FAULT) ? DIGIT_E : c2;
  assign seg3 = (state == S_FAULT) ? DIGIT_E : c3;

`ifdef REFLEX_BEST_EN
  logic [15:0] best;
  logic [15:0] cur;

  assign cur = {c3, c2, c1, c0};

  // Packed BCD compares correctly as binary; saturation exits never update best
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)
      best <= 16'h9999;
    else if (state == S_RUN && stop && cur < best)
      best <= cur;
  end

  assign {seg7, seg6, seg5, seg4} = best;
`else
  assign seg4 = '0;
  assign seg5 = '0;
  assign seg6 = '0;
  assign seg7 = '0;
`endif

endmodule

// File: tb/tb_reflex_timer.sv
// Self-checking bench for reflex_timer: table of trials with a result
// scoreboard, plus fault, saturation and mid-trial reset sequences.
`timescale 1ns/1ps
module tb_reflex_timer;

  // Short tick keeps the 10 000-tick saturation run inside the cycle budget
  localparam int          TD   = 3;
  localparam int          MW   = 5;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef REFLEX_BEST_EN
  localparam logic [15:0] BEST_RST = 16'h9999;
  localparam bit          BEST_ON  = 1'b1;
`else
  localparam logic [15:0] BEST_RST = 16'h0000;
  localparam bit          BEST_ON  = 1'b0;
`endif

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       led;
  logic [3:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  reflex_timer #(
    .TICK_DIV    (TD),
    .MIN_WAIT_MS (MW),
    .LFSR_SEED   (SEED)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .led   (led),
    .seg0  (seg0),
    .seg1  (seg1),
    .seg2  (seg2),
    .seg3  (seg3),
    .seg4  (seg4),
    .seg5  (seg5),
    .seg6  (seg6),
    .seg7  (seg7)
  );

  always #5 ck = ~ck;

  logic [15:0] m_lfsr;
  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cur_v();
    return {seg3, seg2, seg1, seg0};
  endfunction

  function automatic logic [15:0] best_v();
    return {seg7, seg6, seg5, seg4};
  endfunction

  typedef struct {
    int          ticks;
    bit          pick;
    bit          on_tick;
    bit          inj_start;
    logic [15:0] exp_cur;
    logic [15:0] exp_best;
  } vec_t;

  typedef struct {
    logic [15:0] cur;
    logic [15:0] best;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  // Optionally waits for a small lfsr[10:0] so the random delay stays short
  task automatic start_trial(input bit pick, output int n);
    int g;
    g = 0;
    if (pick) begin
      while (m_lfsr[10:0] >= 11'd32 && g < 5000) begin
        @(negedge ck);
        g++;
      end
      check("lfsr_pick_timeout", 32'(g < 5000), 32'd1);
    end
    n = MW + int'(m_lfsr[10:0]);
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    check("wait_cur_cleared", 32'(cur_v()), 32'h0);
    check("wait_led_low", 32'(led), 32'd0);
  endtask

  task automatic wait_led(input int n);
    int  c;
    bit  seg_ok;
    c = 0;
    seg_ok = 1'b1;
    while (!led && c < TD * (n + 2)) begin
      if (cur_v() != 16'h0) seg_ok = 1'b0;
      @(negedge ck);
      c++;
    end
    check("led_rise_cycles", 32'(c), 32'(TD * n));
    check("wait_segs_zero", 32'(seg_ok), 32'd1);
    check("led_high_run", 32'(led), 32'd1);
  endtask

  task automatic run_stop(input int m, input bit inj);
    for (int c = 1; c <= m; c++) begin
      stop  = (c == m);
      start = (inj && c == 10);
      @(negedge ck);
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int   n, m, c;
    bit   led_seen;
    exp_t e;

    vecs[0] = '{237, 1'b0, 1'b0, 1'b1, 16'h0237, 16'h0237};
    vecs[1] = '{412, 1'b1, 1'b0, 1'b0, 16'h0412, 16'h0237};
    vecs[2] = '{150, 1'b1, 1'b0, 1'b0, 16'h0150, 16'h0150};
    vecs[3] = '{ 99, 1'b1, 1'b1, 1'b0, 16'h0099, 16'h0099};

    repeat (3) @(negedge ck);
    check("reset_led", 32'(led), 32'd0);
    check("reset_cur", 32'(cur_v()), 32'h0);
    check("reset_best", 32'(best_v()), 32'(BEST_RST));
    rst_n = 1'b1;

    stop = 1'b1;
    @(negedge ck);
    stop = 1'b0;
    repeat (5) @(negedge ck);
    check("idle_stop_led", 32'(led), 32'd0);
    check("idle_stop_cur", 32'(cur_v()), 32'h0);

    for (int i = 0; i < 4; i++) begin
      start_trial(vecs[i].pick, n);
      wait_led(n);
      m = vecs[i].on_tick ? TD * (vecs[i].ticks + 1) : TD * vecs[i].ticks + 1;
      e.cur  = vecs[i].exp_cur;
      e.best = BEST_ON ? vecs[i].exp_best : 16'h0;
      sb.push_back(e);
      run_stop(m, vecs[i].inj_start);
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("done_cur", 32'(cur_v()), 32'(e.cur));
        check("done_best", 32'(best_v()), 32'(e.best));
        check("done_led", 32'(led), 32'd0);
        repeat (2 * TD) @(negedge ck);
        check("done_frozen", 32'(cur_v()), 32'(e.cur));
      end
    end

    // Early press during WAIT
    start_trial(1'b1, n);
    repeat (3) @(negedge ck);
    stop = 1'b1;
    @(negedge ck);
    stop = 1'b0;
    check("fault_cur", 32'(cur_v()), 32'hEEEE);
    check("fault_led", 32'(led), 32'd0);
    check("fault_best", 32'(best_v()), BEST_ON ? 32'h0099 : 32'h0);
    led_seen = 1'b0;
    repeat (TD * (n + 4)) begin
      @(negedge ck);
      if (led) led_seen = 1'b1;
    end
    check("fault_led_never", 32'(led_seen), 32'd0);
    check("fault_cur_hold", 32'(cur_v()), 32'hEEEE);

    // No reaction: saturate at 9999
    start_trial(1'b1, n);
    wait_led(n);
    c = 0;
    while (led && c < TD * 10000 + 20) begin
      @(negedge ck);
      c++;
    end
    check("sat_cycles", 32'(c), 32'(TD * 10000));
    check("sat_cur", 32'(cur_v()), 32'h9999);
    check("sat_best", 32'(best_v()), BEST_ON ? 32'h0099 : 32'h0);

    // Asynchronous reset in the middle of RUN
    start_trial(1'b1, n);
    wait_led(n);
    repeat (40) @(negedge ck);
    check("run_cur_40", 32'(cur_v()), 32'h0013);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_cur", 32'(cur_v()), 32'h0);
    check("async_rst_best", 32'(best_v()), 32'(BEST_RST));
    @(negedge ck);
    rst_n = 1'b1;
    stop = 1'b1;
    @(negedge ck);
    stop = 1'b0;
    repeat (3 * TD) @(negedge ck);
    check("post_rst_led", 32'(led), 32'd0);
    check("post_rst_cur", 32'(cur_v()), 32'h0);
    check("post_rst_best", 32'(best_v()), 32'(BEST_RST));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
